// File: rtl/tl_pkg.sv
// Shared types and lamp encodings for the two-road traffic-light sequencer.
package tl_pkg;

  typedef enum logic [2:0] {
    AG    = 3'd0,
    AY    = 3'd1,
    RED1  = 3'd2,
    BG    = 3'd3,
    BY    = 3'd4,
    RED2  = 3'd5,
    FLASH = 3'd6
  } tl_state_t;

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Lamp pattern {road A, road B} for a state; f is the flash phase
  function automatic logic [5:0] lamps(input tl_state_t s, input logic f);
    logic [5:0] l;
    case (s)
      AG:      l = {LAMP_G, LAMP_R};
      AY:      l = {LAMP_Y, LAMP_R};
      BG:      l = {LAMP_R, LAMP_G};
      BY:      l = {LAMP_R, LAMP_Y};
      FLASH:   l = f ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
      default: l = {LAMP_R, LAMP_R};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Free-running clock divider producing a one-cycle strobe every CLK_DIV cycles.
module tl_tick_gen #(
  parameter int CLK_DIV = 100000000
) (
  input  logic clk100M,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Strobe is a decode of the terminal count, so it is low while in reset
  assign tick = (cnt == LAST);

  // Count 0..CLK_DIV-1 and wrap on the strobe cycle
  always_ff @(posedge clk100M or negedge clr) begin
    if (!clr) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer: main road A held green until side-road
// demand, all-red clearance between roads, night flashing-yellow mode.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int CLK_DIV   = 100000000,
  parameter int GREEN_A_S = 30,
  parameter int GREEN_B_S = 20,
  parameter int YELLOW_S  = 3,
  parameter int ALLRED_S  = 2
) (
  input  logic       clk100M,
  input  logic       clr,
  input  logic       b_sensor,
  input  logic       night,
  output logic [2:0] a_light,
  output logic [2:0] b_light,
  output logic [7:0] remain,
  output logic       tick
);

  localparam logic [7:0] LEN_GA = 8'(GREEN_A_S);
  localparam logic [7:0] LEN_GB = 8'(GREEN_B_S);
  localparam logic [7:0] LEN_Y  = 8'(YELLOW_S);
  localparam logic [7:0] LEN_AR = 8'(ALLRED_S);

  tl_state_t  state, state_nx;
  logic [7:0] remain_nx;
  logic       flash, flash_nx;
  logic       b_req, b_req_nx;
  logic       enter_bg;
  logic [5:0] lights_nx;

  tl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk100M (clk100M),
    .clr     (clr),
    .tick    (tick)
  );

  // Phase sequencing: night override, countdown, AG demand hold, then advance
  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    flash_nx  = flash;
    enter_bg  = 1'b0;
    if (tick) begin
      if (state == FLASH) begin
        if (night) begin
          flash_nx  = ~flash;
          remain_nx = '0;
        end else begin
          state_nx  = RED2;
          remain_nx = LEN_AR;
          flash_nx  = 1'b0;
        end
      end else if (night) begin
        state_nx  = FLASH;
        flash_nx  = 1'b1;
        remain_nx = '0;
      end else if (remain > 8'd1) begin
        remain_nx = remain - 8'd1;
      end else if (state == AG && !b_req) begin
        // No side-road demand yet: park on the last second of A green
        remain_nx = 8'd1;
      end else begin
        case (state)
          AG:      begin state_nx = AY;   remain_nx = LEN_Y;  end
          AY:      begin state_nx = RED1; remain_nx = LEN_AR; end
          RED1:    begin state_nx = BG;   remain_nx = LEN_GB; enter_bg = 1'b1; end
          BG:      begin state_nx = BY;   remain_nx = LEN_Y;  end
          BY:      begin state_nx = RED2; remain_nx = LEN_AR; end
          default: begin state_nx = AG;   remain_nx = LEN_GA; end
        endcase
      end
    end
    // Demand is sticky; a detect in the BG-entry cycle outranks the clear
    b_req_nx  = b_sensor | (b_req & ~enter_bg);
    lights_nx = lamps(state_nx, flash_nx);
  end

  // State, countdown, demand latch and registered lamp outputs
  always_ff @(posedge clk100M or negedge clr) begin
    if (!clr) begin
      state   <= RED2;
      remain  <= LEN_AR;
      flash   <= 1'b0;
      b_req   <= 1'b0;
      a_light <= LAMP_R;
      b_light <= LAMP_R;
    end else begin
      state   <= state_nx;
      remain  <= remain_nx;
      flash   <= flash_nx;
      b_req   <= b_req_nx;
      a_light <= lights_nx[5:3];
      b_light <= lights_nx[2:0];
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a short tick period.
module tb_traffic_light_ctrl;

  localparam logic [5:0] AGL = 6'b001_100;
  localparam logic [5:0] AYL = 6'b010_100;
  localparam logic [5:0] RRL = 6'b100_100;
  localparam logic [5:0] BGL = 6'b100_001;
  localparam logic [5:0] BYL = 6'b100_010;
  localparam logic [5:0] F1L = 6'b010_010;
  localparam logic [5:0] F0L = 6'b000_000;

  logic       clk100M = 1'b0;
  logic       clr = 1'b0;
  logic       b_sensor = 1'b1;
  logic       night = 1'b0;
  logic [2:0] a_light, b_light;
  logic [7:0] remain;
  logic       tick;
  int         compared = 0;
  int         mismatched = 0;

  traffic_light_ctrl #(
    .CLK_DIV(4), .GREEN_A_S(5), .GREEN_B_S(3), .YELLOW_S(2), .ALLRED_S(1)
  ) dut (
    .clk100M  (clk100M),
    .clr      (clr),
    .b_sensor (b_sensor),
    .night    (night),
    .a_light  (a_light),
    .b_light  (b_light),
    .remain   (remain),
    .tick     (tick)
  );

  always #5 clk100M = ~clk100M;

  // Continuous checks: no conflicting lamps, tick strobe every 4th cycle
  initial begin
    int gap = 0;
    forever begin
      @(negedge clk100M);
      if (!clr) begin
        gap = 0;
      end else begin
        compared++;
        if (!(a_light == 3'b100 || b_light == 3'b100 ||
              (a_light == b_light && (a_light == 3'b010 || a_light == 3'b000)))) begin
          mismatched++;
          $display("FAIL lamp_conflict t=%0t a=%b b=%b required one road red", $time, a_light, b_light);
        end
        if (tick) begin
          compared++;
          if (gap !== 3) begin
            mismatched++;
            $display("FAIL tick_period t=%0t idle_cycles=%0d required 3", $time, gap);
          end
          gap = 0;
        end else begin
          gap++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // Stop at the negedge where tick is high (bounded)
  task automatic find_tick();
    int n = 0;
    do begin
      @(negedge clk100M);
      n++;
    end while (!tick && n < 12);
    if (!tick) begin
      compared++;
      mismatched++;
      $display("FAIL find_tick no tick within 12 cycles got=0 required=1");
    end
  endtask

  // Advance past the next tick and land where the new phase is visible
  task automatic wait_tick();
    find_tick();
    @(negedge clk100M);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    b_sensor = 1'b1;
    night = 1'b0;
    repeat (3) @(negedge clk100M);
    compared++;
    if (a_light !== 3'b100) begin mismatched++; $display("FAIL reset_a got=%b required=100", a_light); end
    compared++;
    if (b_light !== 3'b100) begin mismatched++; $display("FAIL reset_b got=%b required=100", b_light); end
    compared++;
    if (remain !== 8'd1) begin mismatched++; $display("FAIL reset_remain got=%0d required=1", remain); end
    compared++;
    if (tick !== 1'b0) begin mismatched++; $display("FAIL reset_tick got=%b required=0", tick); end
    @(posedge clk100M);
    #3 clr = 1'b1;
  endtask

  task automatic test_sequence();
    logic [13:0] exp [15];
    exp = '{{AGL,8'd5},{AGL,8'd4},{AGL,8'd3},{AGL,8'd2},{AGL,8'd1},
            {AYL,8'd2},{AYL,8'd1},{RRL,8'd1},{BGL,8'd3},{BGL,8'd2},
            {BGL,8'd1},{BYL,8'd2},{BYL,8'd1},{RRL,8'd1},{AGL,8'd5}};
    for (int i = 0; i < 15; i++) begin
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== exp[i]) begin
        mismatched++;
        $display("FAIL sequence[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, exp[i][13:11], exp[i][10:8], exp[i][7:0]);
      end
    end
  endtask

  task automatic test_ag_hold();
    logic [13:0] pre [18];
    logic [13:0] post [15];
    pre = '{{AGL,8'd4},{AGL,8'd3},{AGL,8'd2},{AGL,8'd1},{AYL,8'd2},{AYL,8'd1},
            {RRL,8'd1},{BGL,8'd3},{BGL,8'd2},{BGL,8'd1},{BYL,8'd2},{BYL,8'd1},
            {RRL,8'd1},{AGL,8'd5},{AGL,8'd4},{AGL,8'd3},{AGL,8'd2},{AGL,8'd1}};
    post = '{{AYL,8'd2},{AYL,8'd1},{RRL,8'd1},{BGL,8'd3},{BGL,8'd2},{BGL,8'd1},
             {BYL,8'd2},{BYL,8'd1},{RRL,8'd1},{AGL,8'd5},{AGL,8'd4},{AGL,8'd3},
             {AGL,8'd2},{AGL,8'd1},{AGL,8'd1}};
    b_sensor = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== pre[i]) begin
        mismatched++;
        $display("FAIL hold_pre[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, pre[i][13:11], pre[i][10:8], pre[i][7:0]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== {AGL, 8'd1}) begin
        mismatched++;
        $display("FAIL hold_ag[%0d] got=%b/%b/%0d required=001/100/1", i, a_light, b_light, remain);
      end
    end
    b_sensor = 1'b1;
    @(negedge clk100M);
    b_sensor = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== post[i]) begin
        mismatched++;
        $display("FAIL hold_post[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, post[i][13:11], post[i][10:8], post[i][7:0]);
      end
    end
  endtask

  task automatic test_set_wins();
    logic [13:0] pre [3];
    logic [13:0] post [12];
    pre = '{{AYL,8'd2},{AYL,8'd1},{RRL,8'd1}};
    post = '{{BGL,8'd3},{BGL,8'd2},{BGL,8'd1},{BYL,8'd2},{BYL,8'd1},{RRL,8'd1},
             {AGL,8'd5},{AGL,8'd4},{AGL,8'd3},{AGL,8'd2},{AGL,8'd1},{AYL,8'd2}};
    b_sensor = 1'b1;
    @(negedge clk100M);
    b_sensor = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== pre[i]) begin
        mismatched++;
        $display("FAIL setwins_pre[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, pre[i][13:11], pre[i][10:8], pre[i][7:0]);
      end
    end
    // Detect asserted exactly in the tick cycle that enters BG
    find_tick();
    b_sensor = 1'b1;
    @(negedge clk100M);
    b_sensor = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== post[i]) begin
        mismatched++;
        $display("FAIL setwins_post[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, post[i][13:11], post[i][10:8], post[i][7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_bg();
    int n = 0;
    wait_tick();
    wait_tick();
    wait_tick();
    compared++;
    if ({a_light, b_light, remain} !== {BGL, 8'd3}) begin
      mismatched++;
      $display("FAIL midbg_enter got=%b/%b/%0d required=100/001/3", a_light, b_light, remain);
    end
    @(posedge clk100M);
    #3 clr = 1'b0;
    #1;
    compared++;
    if ({a_light, b_light, remain} !== {RRL, 8'd1}) begin
      mismatched++;
      $display("FAIL midbg_async got=%b/%b/%0d required=100/100/1", a_light, b_light, remain);
    end
    compared++;
    if (tick !== 1'b0) begin mismatched++; $display("FAIL midbg_tick got=%b required=0", tick); end
    @(posedge clk100M);
    #3 clr = 1'b1;
    do begin
      @(negedge clk100M);
      n++;
    end while (!tick && n < 12);
    compared++;
    if (n !== 4 || tick !== 1'b1) begin
      mismatched++;
      $display("FAIL midbg_first_tick got=%0d cycles required=4", n);
    end
    @(negedge clk100M);
    compared++;
    if ({a_light, b_light, remain} !== {AGL, 8'd5}) begin
      mismatched++;
      $display("FAIL midbg_after got=%b/%b/%0d required=001/100/5", a_light, b_light, remain);
    end
  endtask

  task automatic test_night();
    logic [13:0] pre [5];
    logic [13:0] post [6];
    pre = '{{AGL,8'd4},{AGL,8'd3},{AGL,8'd2},{AGL,8'd1},{AYL,8'd2}};
    post = '{{F1L,8'd0},{F0L,8'd0},{F1L,8'd0},{F0L,8'd0},{RRL,8'd1},{AGL,8'd5}};
    b_sensor = 1'b1;
    @(negedge clk100M);
    b_sensor = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== pre[i]) begin
        mismatched++;
        $display("FAIL night_pre[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, pre[i][13:11], pre[i][10:8], pre[i][7:0]);
      end
    end
    night = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) night = 1'b0;
      wait_tick();
      compared++;
      if ({a_light, b_light, remain} !== post[i]) begin
        mismatched++;
        $display("FAIL night_post[%0d] got=%b/%b/%0d required=%b/%b/%0d", i,
                 a_light, b_light, remain, post[i][13:11], post[i][10:8], post[i][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ag_hold();
    test_set_wins();
    test_reset_mid_bg();
    test_night();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
